// File: rtl/multi_ported_sram_pkg.sv
// Shared types and constants for the XOR-based multi-ported SRAM.
// The pending-write record is sized by the default data width and depth.
package multi_ported_sram_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        INIT = 1'b1
    } fsm_t;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    // Row inside column col that holds the copy read by writer rd_wr for its XOR operand.
    function automatic int wr_row(input int num_r, input int rd_wr, input int col);
        return (rd_wr < col) ? (num_r + rd_wr) : (num_r + rd_wr - 1);
    endfunction

    typedef struct packed {
        logic                     vld;
        logic [$clog2(DEPTH)-1:0] addr;
        logic [DATA_W-1:0]        data;
        logic [DATA_W-1:0]        col_val;
    } pending_wr_t;

endpackage

// File: rtl/dpsram.sv
// Simple dual-port RAM bank: one synchronous write port, one asynchronous read port.
module dpsram #(
    parameter int W = 32,
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic [$clog2(N)-1:0] raddr,
    output logic [W-1:0]         rdata
);

    logic [W-1:0] mem_r [N];

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/multi_ported_sram_init_ctrl.sv
// Zero-fill sweep controller: IDLE/INIT FSM, address counter and busy flag.
module multi_ported_sram_init_ctrl
    import multi_ported_sram_pkg::*;
#(
    parameter int N             = DEPTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    output logic                 busy_w,
    output logic                 init_we,
    output logic [addr_w(N)-1:0] init_addr
);

    localparam int AW = addr_w(N);

    fsm_t          state_r;
    fsm_t          state_nxt_s;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_nxt_s;
    logic          start_r;

    // State, counter and one-shot start-after-reset flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {AW{1'b0}};
            start_r <= INIT_ON_RESET;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            start_r <= 1'b0;
        end
    end

    // Next-state and sweep counter
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (start_r || init) begin
                    state_nxt_s = INIT;
                    cnt_nxt_s   = {AW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INIT: begin
                if (cnt_r == AW'(N - 1)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {AW{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + AW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {AW{1'b0}};
            end
        endcase
    end

    assign busy_w    = (state_r == INIT);
    assign init_we   = busy_w;
    assign init_addr = cnt_r;

endmodule

// File: rtl/multi_ported_sram_xor_fwd.sv
// XOR-based multi-ported SRAM: one bank column per writer, value = XOR of columns,
// with read/write forwarding from the pending-write stage and write arbitration.
module multi_ported_sram_xor_fwd
    import multi_ported_sram_pkg::*;
#(
    parameter int NUM_W         = 2,
    parameter int NUM_R         = 2,
    parameter int W             = DATA_W,
    parameter int N             = DEPTH,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_R-1:0]           ren,
    input  logic [NUM_R*addr_w(N)-1:0] raddr,
    output logic [NUM_R*W-1:0]         rdata,
    output logic [NUM_R-1:0]           rvalid,
    input  logic [NUM_W-1:0]           wen,
    input  logic [NUM_W*addr_w(N)-1:0] waddr,
    input  logic [NUM_W*W-1:0]         wdata,
    output logic [NUM_W-1:0]           wr_conflict,
    input  logic                       init,
    output logic                       busy_w
);

    localparam int AW = addr_w(N);
    localparam int NB = NUM_R + NUM_W - 1;

    logic          init_we_s;
    logic [AW-1:0] init_addr_s;
    logic [W-1:0]  bank_q_s  [NUM_W][NB];
    logic [NUM_W-1:0] col_we_s;
    logic [AW-1:0] col_wa_s  [NUM_W];
    logic [W-1:0]  col_wd_s  [NUM_W];
    logic [W-1:0]  new_col_s [NUM_W];
    logic [W-1:0]  rd_val_s  [NUM_R];
    logic [NUM_W-1:0] win_s;
    logic [NUM_W-1:0] lose_s;
    pending_wr_t   pend_r    [NUM_W];

    multi_ported_sram_init_ctrl #(
        .N            (N),
        .INIT_ON_RESET(INIT_ON_RESET)
    ) u_init_ctrl (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
        .busy_w   (busy_w),
        .init_we  (init_we_s),
        .init_addr(init_addr_s)
    );

    // Rows 0..NUM_R-1 serve the read ports; the remaining rows serve the other writers.
    for (genvar y = 0; y < NUM_W; y++) begin : g_col
        for (genvar b = 0; b < NB; b++) begin : g_bank
            logic [AW-1:0] ra_s;
            if (b < NUM_R) begin : g_rd
                assign ra_s = raddr[b*AW +: AW];
            end else begin : g_wr
                localparam int WR = ((b - NUM_R) < y) ? (b - NUM_R) : (b - NUM_R + 1);
                assign ra_s = waddr[WR*AW +: AW];
            end
            dpsram #(.W(W), .N(N)) u_bank (
                .clk  (clk),
                .we   (col_we_s[y]),
                .waddr(col_wa_s[y]),
                .wdata(col_wd_s[y]),
                .raddr(ra_s),
                .rdata(bank_q_s[y][b])
            );
        end
    end

    // Same-cycle address conflicts: the lowest-indexed writer wins
    always_comb begin
        win_s  = {NUM_W{1'b0}};
        lose_s = {NUM_W{1'b0}};
        for (int y = 0; y < NUM_W; y++) begin
            win_s[y] = wen[y] & ~busy_w;
            for (int x = 0; x < y; x++) begin
                win_s[y] = win_s[y] & ~(wen[x] & (waddr[x*AW +: AW] == waddr[y*AW +: AW]));
            end
            lose_s[y] = wen[y] & ~busy_w & ~win_s[y];
        end
    end

    // New column value; a pending column write to the same address supplies its operand
    always_comb begin
        for (int y = 0; y < NUM_W; y++) begin
            new_col_s[y] = wdata[y*W +: W];
            for (int x = 0; x < NUM_W; x++) begin
                if (x != y) begin
                    new_col_s[y] = new_col_s[y] ^
                        ((pend_r[x].vld && (pend_r[x].addr == waddr[y*AW +: AW])) ?
                         pend_r[x].col_val : bank_q_s[x][wr_row(NUM_R, y, x)]);
                end else begin
                    new_col_s[y] = new_col_s[y];
                end
            end
        end
    end

    // Pending-write stage and conflict flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int y = 0; y < NUM_W; y++) begin
                pend_r[y] <= {$bits(pending_wr_t){1'b0}};
            end
            wr_conflict <= {NUM_W{1'b0}};
        end else begin
            for (int y = 0; y < NUM_W; y++) begin
                pend_r[y].vld     <= win_s[y];
                pend_r[y].addr    <= waddr[y*AW +: AW];
                pend_r[y].data    <= wdata[y*W +: W];
                pend_r[y].col_val <= new_col_s[y];
            end
            wr_conflict <= lose_s;
        end
    end

    // Bank write ports: the zero-fill sweep overrides pending writes
    always_comb begin
        for (int y = 0; y < NUM_W; y++) begin
            col_we_s[y] = init_we_s | pend_r[y].vld;
            col_wa_s[y] = init_we_s ? init_addr_s : pend_r[y].addr;
            col_wd_s[y] = init_we_s ? {W{1'b0}} : pend_r[y].col_val;
        end
    end

    // Read value: XOR of the row, or the data of a pending write to that address
    always_comb begin
        for (int r = 0; r < NUM_R; r++) begin
            rd_val_s[r] = {W{1'b0}};
            for (int y = 0; y < NUM_W; y++) begin
                rd_val_s[r] = rd_val_s[r] ^ bank_q_s[y][r];
            end
            for (int y = 0; y < NUM_W; y++) begin
                rd_val_s[r] = (pend_r[y].vld && (pend_r[y].addr == raddr[r*AW +: AW])) ?
                              pend_r[y].data : rd_val_s[r];
            end
        end
    end

    // Registered read outputs; rdata holds while no read is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= {NUM_R{1'b0}};
            rdata  <= {(NUM_R*W){1'b0}};
        end else begin
            for (int r = 0; r < NUM_R; r++) begin
                rvalid[r] <= ren[r] & ~busy_w;
                if (ren[r] && !busy_w) begin
                    rdata[r*W +: W] <= rd_val_s[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_ported_sram_xor_fwd.sv
// Scoreboard bench for multi_ported_sram_xor_fwd: a behavioural memory model predicts
// read data, conflicts and busy cycles; expected reads are queued and compared on rvalid.
module tb_multi_ported_sram_xor_fwd;

    localparam int NW  = 2;
    localparam int NR  = 2;
    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int AW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    ren;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rvalid;
    logic [NW-1:0]    wen;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW-1:0]    wr_conflict;
    logic             init;
    logic             busy_w;

    int          checks = 0;
    int          errors = 0;
    int          m_busy = 0;
    logic [31:0] model [DEP];
    logic [31:0] exp_q [NR][$];
    logic [31:0] hold_exp [NR];
    logic        hold_vld [NR];

    multi_ported_sram_xor_fwd #(
        .NUM_W(NW), .NUM_R(NR), .W(DW), .N(DEP), .INIT_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wr_conflict(wr_conflict),
        .init(init), .busy_w(busy_w)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic model_clear();
        for (int a = 0; a < DEP; a++) model[a] = 32'd0;
    endtask

    // One clock: drive inputs, predict, clock, then check outputs of that cycle.
    task automatic step(input logic [1:0] r_en, input logic [3:0] ra0, input logic [3:0] ra1,
                        input logic [1:0] w_en, input logic [3:0] wa0, input logic [3:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1, input logic do_init);
        logic        accept;
        logic [1:0]  exp_rv;
        logic [1:0]  exp_wc;
        logic [3:0]  ra [NR];
        logic [31:0] exp_d;
        accept = (m_busy == 0);
        ren = r_en; raddr = {ra1, ra0};
        wen = w_en; waddr = {wa1, wa0}; wdata = {wd1, wd0};
        init = do_init;
        ra[0] = ra0; ra[1] = ra1;
        exp_rv = 2'b00;
        exp_wc = 2'b00;
        if (accept) begin
            for (int r = 0; r < NR; r++) begin
                if (r_en[r]) begin
                    exp_q[r].push_back(model[ra[r]]);
                    exp_rv[r] = 1'b1;
                end
            end
            if (w_en == 2'b11 && wa0 == wa1) exp_wc = 2'b10;
            if (w_en[0]) model[wa0] = wd0;
            if (w_en[1] && !(w_en[0] && wa0 == wa1)) model[wa1] = wd1;
            if (do_init) begin
                m_busy = DEP;
                model_clear();
            end
        end else begin
            m_busy = m_busy - 1;
        end
        @(posedge clk);
        #1;
        init = 1'b0;
        checks++;
        if (busy_w !== (m_busy > 0)) begin
            errors++;
            $display("FAIL busy_w: got %0b expected %0b at %0t", busy_w, (m_busy > 0), $time);
        end
        checks++;
        if (rvalid !== exp_rv) begin
            errors++;
            $display("FAIL rvalid: got %b expected %b at %0t", rvalid, exp_rv, $time);
        end
        checks++;
        if (wr_conflict !== exp_wc) begin
            errors++;
            $display("FAIL wr_conflict: got %b expected %b at %0t", wr_conflict, exp_wc, $time);
        end
        for (int r = 0; r < NR; r++) begin
            if (rvalid[r] === 1'b1) begin
                checks++;
                if (exp_q[r].size() == 0) begin
                    errors++;
                    $display("FAIL rdata%0d: got unexpected read 0x%h, expected none at %0t",
                             r, rdata[r*DW +: DW], $time);
                end else begin
                    exp_d = exp_q[r].pop_front();
                    if (rdata[r*DW +: DW] !== exp_d) begin
                        errors++;
                        $display("FAIL rdata%0d: got 0x%h expected 0x%h at %0t",
                                 r, rdata[r*DW +: DW], exp_d, $time);
                    end
                    hold_exp[r] = exp_d;
                    hold_vld[r] = 1'b1;
                end
            end else if (hold_vld[r]) begin
                checks++;
                if (rdata[r*DW +: DW] !== hold_exp[r]) begin
                    errors++;
                    $display("FAIL rdata%0d_hold: got 0x%h expected 0x%h at %0t",
                             r, rdata[r*DW +: DW], hold_exp[r], $time);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic check_drained(input string name);
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (exp_q[r].size() != 0) begin
                errors++;
                $display("FAIL %s_drain%0d: got %0d outstanding reads expected 0", name, r, exp_q[r].size());
                exp_q[r].delete();
            end
        end
    endtask

    task automatic clear_inputs();
        ren = 2'b00; raddr = 8'd0; wen = 2'b00; waddr = 8'd0; wdata = 64'd0; init = 1'b0;
    endtask

    // Sweep restarts on the first edge after release; model it from there.
    task automatic release_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy_w !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got %0b expected 1", busy_w);
        end
        m_busy = DEP;
        model_clear();
    endtask

    task automatic check_in_reset(input string name);
        checks++;
        if (busy_w !== 1'b0 || rvalid !== 2'b00 || wr_conflict !== 2'b00) begin
            errors++;
            $display("FAIL %s: got busy_w=%0b rvalid=%b wr_conflict=%b expected 0/00/00",
                     name, busy_w, rvalid, wr_conflict);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        for (int r = 0; r < NR; r++) hold_vld[r] = 1'b0;
        #12;
        check_in_reset("reset_state");
        release_reset();
        idle(DEP);
        for (int a = 0; a < DEP; a++) begin
            step(2'b11, 4'(a), 4'(DEP - 1 - a), 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        end
        idle(1);
        check_drained("reset");
    endtask

    task automatic test_two_port_write();
        step(2'b00, 4'd0, 4'd0, 2'b11, 4'd3, 4'd7, 32'hAAAA_0001, 32'h5555_0002, 1'b0);
        idle(1);
        step(2'b11, 4'd3, 4'd7, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        step(2'b11, 4'd7, 4'd3, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        idle(1);
        check_drained("two_port");
    endtask

    task automatic test_raw_fwd();
        step(2'b01, 4'd5, 4'd0, 2'b01, 4'd5, 4'd0, 32'h0000_1234, 32'd0, 1'b0);
        step(2'b10, 4'd0, 4'd5, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        step(2'b01, 4'd5, 4'd0, 2'b10, 4'd0, 4'd5, 32'd0, 32'h0000_9876, 1'b0);
        step(2'b11, 4'd5, 4'd5, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        idle(1);
        check_drained("raw_fwd");
    endtask

    task automatic test_conflict();
        step(2'b00, 4'd0, 4'd0, 2'b11, 4'd9, 4'd9, 32'h11, 32'h22, 1'b0);
        step(2'b10, 4'd0, 4'd9, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        idle(1);
        step(2'b11, 4'd9, 4'd9, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        idle(1);
        check_drained("conflict");
    endtask

    task automatic test_waw();
        step(2'b00, 4'd0, 4'd0, 2'b10, 4'd0, 4'd4, 32'd0, 32'hF0, 1'b0);
        step(2'b00, 4'd0, 4'd0, 2'b01, 4'd4, 4'd0, 32'h0F, 32'd0, 1'b0);
        idle(1);
        step(2'b11, 4'd4, 4'd4, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        idle(1);
        check_drained("waw");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            step(2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                 $urandom, $urandom, 1'b0);
        end
        for (int a = 0; a < DEP; a++) begin
            step(2'b11, 4'(a), 4'(a), 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        end
        idle(1);
        check_drained("back_to_back");
    endtask

    task automatic test_init_busy();
        step(2'b11, 4'd3, 4'd9, 2'b11, 4'd6, 4'd8, 32'hDEAD_0006, 32'hBEEF_0008, 1'b1);
        for (int i = 0; i < DEP + 2; i++) begin
            step(2'b11, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                 2'b11, 4'(i), 4'(15 - i), $urandom, $urandom, (i == 4));
        end
        for (int a = 0; a < DEP; a++) begin
            step(2'b11, 4'(a), 4'(15 - a), 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        end
        idle(1);
        check_drained("init_busy");
    endtask

    task automatic test_reset_mid_sweep();
        step(2'b00, 4'd0, 4'd0, 2'b11, 4'd1, 4'd2, 32'h0000_0101, 32'h0000_0202, 1'b0);
        step(2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(2'b00, 4'd0, 4'd0, 2'b11, 4'd1, 4'd2, $urandom, $urandom, 1'b0);
        end
        #2;
        rst = 1'b0;
        #1;
        check_in_reset("mid_sweep_reset");
        for (int r = 0; r < NR; r++) hold_vld[r] = 1'b0;
        release_reset();
        for (int i = 0; i < 3 * DEP && m_busy > 0; i++) begin
            step(2'b00, 4'd0, 4'd0, 2'b11, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                 $urandom | 32'd1, $urandom | 32'd1, 1'b0);
        end
        for (int a = 0; a < DEP; a++) begin
            step(2'b11, 4'(a), 4'(a), 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        end
        idle(1);
        check_drained("mid_sweep");
    endtask

    initial begin
        test_reset();
        test_two_port_write();
        test_raw_fwd();
        test_conflict();
        test_waw();
        test_back_to_back();
        test_init_busy();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
